accum_reduce_issue: RTL and testbench
=====================================

Name: accum_reduce_issue

Overview:
Downstream consumer of the operand accumulator. Accepts one completed operand set (r0..r2 plus valid bits, framed by done) together with an opcode. Folds the set left-to-right into one result at one operand per cycle. Presents the result to the writeback stage on a valid/ready handshake.

Parameters:
WIDTH, 8, data width of operands and result
NUM_OPS, 3, maximum operand slots (fixed at 3; r0..r2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
done  in  1  operand set complete; qualifies r*, r*_valid, op
op  in  3  reduction opcode (see package)
r0  in  WIDTH  operand slot 0
r1  in  WIDTH  operand slot 1
r2  in  WIDTH  operand slot 2
r0_valid  in  1  slot 0 holds an operand
r1_valid  in  1  slot 1 holds an operand
r2_valid  in  1  slot 2 holds an operand
in_ready  out  1  block can accept a set (high only in IDLE)
result  out  WIDTH  reduced value
carry  out  1  ADD: any carry-out; SUB: any borrow; else 0
zero  out  1  result == 0
result_valid  out  1  result/flags valid; held until result_ready
result_ready  in  1  downstream accepts result
set_err  out  1  one-cycle pulse on rejected set
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, carry, zero, result_valid, set_err=0; internal operand regs, idx, count=0. in_ready=1 once rst_n deasserts.
- Accept: done && in_ready at an edge. Latch r0..r2 and op. Compute count from the valid bits.
- Legal valid patterns: 001 (count 1), 011 (count 2), 111 (count 3), written as {r2,r1,r0}.
- Any other pattern, including 000: the set is rejected. set_err pulses the next cycle, state stays IDLE, no result.
- done while not IDLE: ignored and dropped. set_err pulses for one cycle.
- FSM IDLE -> REDUCE -> HOLD -> IDLE.
  - IDLE, on accept: acc<=r0, carry<=0, idx<=1. Go to HOLD if count==1, else REDUCE.
  - REDUCE: acc<=acc op r[idx], carry|=carry/borrow of this step, idx++. Leave for HOLD when idx==count-1.
  - HOLD: result_valid=1; result=acc; zero=(acc==0). On result_ready, go to IDLE and drop result_valid on the next cycle.
- Latency: result_valid rises exactly count clock edges after the accepting edge (1, 2 or 3).
- result, carry and zero are stable while result_valid=1 and result_ready=0.
- result_ready is ignored outside HOLD.
- Throughput: a new set can be accepted on the edge after HOLD exits, because in_ready comes from the registered state.
- Opcodes, all WIDTH-bit and unsigned, wrap-around:
  - 000 ADD
  - 001 SUB (r0-r1-r2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MAX
  - 110 MIN
  - 111 PASS (result=r0; steps still take count cycles)
- Reset mid-operation: everything returns to reset values immediately, and any in-flight set is discarded.

Optional Feature:
ACCUM_REDUCE_STATS_EN
- Defined: adds output stat_sets [15:0], counting results handed off (result_valid && result_ready), and output stat_errs [15:0], counting set_err pulses. Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Package accum_pkg: op_e enum (OP_ADD..OP_PASS, 3-bit), state_e enum (IDLE, REDUCE, HOLD), WIDTH_DEF=8, NUM_OPS=3.
- One sub-module, reduce_alu: combinational step taking (a, b, op) and returning (y, cout). Instantiated once; the FSM owns all registers.

Test Plan:
- ADD, valid 111, r=40/50/60 -> result_valid 3 edges after accept, result=150, carry=0, zero=0.
- ADD, valid 011, r=200/100 -> result=44, carry=1, latency 2.
- SUB, valid 111, r=10/4/6 -> result=0, zero=1, carry=0. SUB, 011, r=5/9 -> result=252, carry=1.
- MAX, valid 001, r0=77 -> result=77 after 1 edge. With result_ready=0 for 5 cycles, result_valid and result hold and in_ready=0.
- valid 101 or 000 with done -> set_err pulses once, no result_valid, in_ready stays 1. done during REDUCE -> set_err pulses, in-flight result is unchanged.
- rst_n pulsed low mid-REDUCE -> all outputs 0 immediately. A set accepted after release completes normally.

Source files
------------

// File: rtl/accum_reduce_issue_pkg.sv
// Shared types and constants for the operand-set reduction block.
// Opcode and FSM state encodings live here so the bench and RTL agree on them.
package accum_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NUM_OPS   = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MAX  = 3'b101,
        OP_MIN  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Operand count for a {r2,r1,r0} valid pattern; 0 marks a pattern that must be rejected.
    function automatic logic [1:0] valid_count(input logic [2:0] valid);
        case (valid)
            3'b001:  valid_count = 2'd1;
            3'b011:  valid_count = 2'd2;
            3'b111:  valid_count = 2'd3;
            default: valid_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/accum_reduce_issue_if.sv
// Operand-set input and result handshake bundle for accum_reduce_issue.
// slave is the reduction block, master is the accumulator/writeback side.
interface accum_reduce_issue_if #(parameter int WIDTH = accum_pkg::WIDTH_DEF);
    import accum_pkg::*;

    logic             done;
    op_e              op;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             r0_valid;
    logic             r1_valid;
    logic             r2_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             result_valid;
    logic             result_ready;
    logic             set_err;
    logic             busy;

    modport slave (
        input  done, op, r0, r1, r2, r0_valid, r1_valid, r2_valid, result_ready,
        output in_ready, result, carry, zero, result_valid, set_err, busy
    );

    modport master (
        output done, op, r0, r1, r2, r0_valid, r1_valid, r2_valid, result_ready,
        input  in_ready, result, carry, zero, result_valid, set_err, busy
    );

endinterface

// File: rtl/accum_reduce_issue_alu.sv
// Single combinational fold step y = a op b, with carry (ADD) or borrow (SUB) out.
module reduce_alu
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        y    = a;
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MAX:  y = (a > b) ? a : b;
            OP_MIN:  y = (a < b) ? a : b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/accum_reduce_issue.sv
// Folds one operand set left-to-right, one operand per cycle, and offers the result on valid/ready.
// Optional `ACCUM_REDUCE_STATS_EN adds saturating hand-off and error counters.
module accum_reduce_issue
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accum_reduce_issue_if.slave  bus
`ifdef ACCUM_REDUCE_STATS_EN
    ,
    output logic [15:0]          stat_sets,
    output logic [15:0]          stat_errs
`endif
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] opnd [NUM_OPS];
    op_e              op_q;
    logic [1:0]       idx;
    logic [1:0]       count;
    logic [WIDTH-1:0] acc;
    logic             cy_acc;

    logic [1:0]       in_count;
    logic             accept;
    logic             err_cond;
    logic             handoff;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;

    assign in_count = valid_count({bus.r2_valid, bus.r1_valid, bus.r0_valid});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (in_count == 2'd1) ? HOLD : REDUCE;
            REDUCE:  if (idx == count - 2'd1) state_nxt = HOLD;
            HOLD:    if (handoff) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A done outside IDLE, or with an illegal valid pattern, is dropped and flagged.
    always_comb begin
        bus.in_ready = (state == IDLE);
        bus.busy     = (state != IDLE);
        accept       = bus.done && (state == IDLE) && (in_count != 2'd0);
        err_cond     = bus.done && ((state != IDLE) || (in_count == 2'd0));
        handoff      = (state == HOLD) && bus.result_valid && bus.result_ready;
    end

    always_comb begin
        case (idx)
            2'd0:    alu_b = opnd[0];
            2'd1:    alu_b = opnd[1];
            default: alu_b = opnd[2];
        endcase
    end

    reduce_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (acc),
        .b    (alu_b),
        .op   (op_q),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // NOTE: the operand registers are reset too, so an aborted set leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) opnd[i] <= '0;
            op_q             <= OP_ADD;
            idx              <= 2'd0;
            count            <= 2'd0;
            acc              <= '0;
            cy_acc           <= 1'b0;
            bus.result       <= '0;
            bus.carry        <= 1'b0;
            bus.zero         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.set_err      <= 1'b0;
        end else begin
            bus.set_err <= err_cond;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opnd[0] <= bus.r0;
                        opnd[1] <= bus.r1;
                        opnd[2] <= bus.r2;
                        op_q    <= bus.op;
                        count   <= in_count;
                        acc     <= bus.r0;
                        cy_acc  <= 1'b0;
                        idx     <= 2'd1;
                    end
                end
                REDUCE: begin
                    acc    <= alu_y;
                    cy_acc <= cy_acc | alu_cout;
                    idx    <= idx + 2'd1;
                end
                HOLD: begin
                    // Flags are captured once on entry so they stay frozen while stalled.
                    if (!bus.result_valid) begin
                        bus.result_valid <= 1'b1;
                        bus.result       <= acc;
                        bus.carry        <= cy_acc;
                        bus.zero         <= (acc == '0);
                    end else if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ACCUM_REDUCE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sets <= '0;
            stat_errs <= '0;
        end else begin
            if (handoff && stat_sets != 16'hFFFF)     stat_sets <= stat_sets + 16'd1;
            if (bus.set_err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_reduce_issue.sv
// Directed bench for accum_reduce_issue: a vector table for the fold results and latency,
// plus hand-written sequences for stall, reject, drop-while-busy and mid-operation reset.
module tb_accum_reduce_issue;
    import accum_pkg::*;

    typedef struct {
        string      name;
        op_e        op;
        logic [2:0] valid;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] exp_res;
        logic       exp_c;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    accum_reduce_issue_if #(.WIDTH(8)) bus ();

`ifdef ACCUM_REDUCE_STATS_EN
    logic [15:0] stat_sets;
    logic [15:0] stat_errs;
`endif

    accum_reduce_issue #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ACCUM_REDUCE_STATS_EN
        ,
        .stat_sets (stat_sets),
        .stat_errs (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input op_e op, input logic [2:0] valid,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                input logic [7:0] exp_res, input logic exp_c, input logic exp_z,
                                input int exp_lat);
        vec_t v;
        v.name = name; v.op = op; v.valid = valid;
        v.r0 = r0; v.r1 = r1; v.r2 = r2;
        v.exp_res = exp_res; v.exp_c = exp_c; v.exp_z = exp_z; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Presents one set at the falling edge; returns #1 after the accepting edge with done low.
    task automatic start_set(input op_e op, input logic [2:0] valid,
                             input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        @(negedge clk);
        bus.done     = 1'b1;
        bus.op       = op;
        bus.r0       = r0;
        bus.r1       = r1;
        bus.r2       = r2;
        bus.r0_valid = valid[0];
        bus.r1_valid = valid[1];
        bus.r2_valid = valid[2];
        @(posedge clk);
        #1;
        bus.done = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.result_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check({name, " valid_dropped"}, bus.result_valid, 0);
        check({name, " in_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " in_ready"}, bus.in_ready, 1);
        start_set(v.op, v.valid, v.r0, v.r1, v.r2);
        wait_valid(lat);
        check({v.name, " latency"}, lat, v.exp_lat);
        check({v.name, " result"}, bus.result, v.exp_res);
        check({v.name, " carry"}, bus.carry, v.exp_c);
        check({v.name, " zero"}, bus.zero, v.exp_z);
        handshake(v.name);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   lat;

        vecs[0]  = mk("add3",   OP_ADD,  3'b111, 8'd40,   8'd50,   8'd60,  8'd150,  1'b0, 1'b0, 3);
        vecs[1]  = mk("add2c",  OP_ADD,  3'b011, 8'd200,  8'd100,  8'hEE,  8'd44,   1'b1, 1'b0, 2);
        vecs[2]  = mk("sub3z",  OP_SUB,  3'b111, 8'd10,   8'd4,    8'd6,   8'd0,    1'b0, 1'b1, 3);
        vecs[3]  = mk("and3",   OP_AND,  3'b111, 8'hF0,   8'h3C,   8'hFF,  8'h30,   1'b0, 1'b0, 3);
        vecs[4]  = mk("or2",    OP_OR,   3'b011, 8'h0F,   8'hA0,   8'h55,  8'hAF,   1'b0, 1'b0, 2);
        vecs[5]  = mk("xor3z",  OP_XOR,  3'b111, 8'hFF,   8'h0F,   8'hF0,  8'h00,   1'b0, 1'b1, 3);
        vecs[6]  = mk("max3",   OP_MAX,  3'b111, 8'd10,   8'd200,  8'd100, 8'd200,  1'b0, 1'b0, 3);
        vecs[7]  = mk("min3",   OP_MIN,  3'b111, 8'd9,    8'd3,    8'd7,   8'd3,    1'b0, 1'b0, 3);
        vecs[8]  = mk("pass3",  OP_PASS, 3'b111, 8'd5,    8'd6,    8'd7,   8'd5,    1'b0, 1'b0, 3);
        vecs[9]  = mk("add3c",  OP_ADD,  3'b111, 8'd200,  8'd100,  8'd10,  8'd54,   1'b1, 1'b0, 3);
        vecs[10] = mk("sub3b",  OP_SUB,  3'b111, 8'd3,    8'd5,    8'd1,   8'd253,  1'b1, 1'b0, 3);
        vecs[11] = mk("sub2b",  OP_SUB,  3'b011, 8'd5,    8'd9,    8'd0,   8'd252,  1'b1, 1'b0, 2);

        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.done         = 1'b0;
        bus.op           = OP_ADD;
        bus.r0           = '0;
        bus.r1           = '0;
        bus.r2           = '0;
        bus.r0_valid     = 1'b0;
        bus.r1_valid     = 1'b0;
        bus.r2_valid     = 1'b0;
        bus.result_ready = 1'b0;

        #12;
        check("rst result_valid", bus.result_valid, 0);
        check("rst result", bus.result, 0);
        check("rst set_err", bus.set_err, 0);
        check("rst busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", bus.in_ready, 1);

        // Single-operand set, then a five-cycle stall with the result held.
        start_set(OP_MAX, 3'b001, 8'd77, 8'd1, 8'd2);
        wait_valid(lat);
        check("hold latency", lat, 1);
        check("hold result", bus.result, 77);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold valid", bus.result_valid, 1);
            check("hold result_stable", bus.result, 77);
            check("hold in_ready", bus.in_ready, 0);
        end
        handshake("hold");

        // Illegal valid patterns are rejected with a single set_err pulse.
        start_set(OP_ADD, 3'b101, 8'd1, 8'd2, 8'd3);
        check("rej101 set_err", bus.set_err, 1);
        check("rej101 in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("rej101 set_err_pulse", bus.set_err, 0);
        check("rej101 no_result", bus.result_valid, 0);
        start_set(OP_ADD, 3'b000, 8'd1, 8'd2, 8'd3);
        check("rej000 set_err", bus.set_err, 1);
        check("rej000 busy", bus.busy, 0);
        @(posedge clk);
        #1;
        check("rej000 set_err_pulse", bus.set_err, 0);
        check("rej000 no_result", bus.result_valid, 0);

        // done while reducing is dropped and the in-flight set completes unchanged.
        start_set(OP_ADD, 3'b111, 8'd40, 8'd50, 8'd60);
        start_set(OP_OR, 3'b001, 8'd1, 8'd0, 8'd0);
        check("drop set_err", bus.set_err, 1);
        check("drop busy", bus.busy, 1);
        wait_valid(lat);
        check("drop latency", lat, 2);
        check("drop result", bus.result, 150);
        check("drop carry", bus.carry, 0);
        handshake("drop");

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset mid-REDUCE clears the held 252/carry result from the last vector.
        start_set(OP_ADD, 3'b111, 8'd1, 8'd2, 8'd3);
        check("mid busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid result", bus.result, 0);
        check("mid carry", bus.carry, 0);
        check("mid result_valid", bus.result_valid, 0);
        check("mid busy_cleared", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("post_rst", OP_ADD, 3'b011, 8'd1, 8'd2, 8'd0, 8'd3, 1'b0, 1'b0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
